// File: rtl/ledgame_pkg.sv
// Shared types and helpers for the LED game front end.
package ledgame_pkg;

  localparam int unsigned STATE_W = 2;

  // Debounce state encoding
  typedef enum logic [STATE_W-1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_e;

  // Debounced level implied by a state: high while pressed or confirming a release
  function automatic logic state_level(input db_state_e s);
    return (s == S_HIGH) || (s == S_FALL);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser for asynchronous single-bit inputs.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flops, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronises btn_in, accepts a level change only after
// DEBOUNCE_CYCLES stable cycles, and emits one-cycle press/release pulses.
module button_debounce
  import ledgame_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic toggle,
  output logic release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic                 btn_s;
  db_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 toggle_q, toggle_d;
  logic                 release_q, release_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (btn_s)
  );

  // Next state, stability counter and pulse generation.
  // The count check takes priority so that DEBOUNCE_CYCLES stable cycles
  // (counting the entry cycle) are enough to accept a change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    toggle_d  = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      S_LOW: begin
        if (btn_s) begin
          state_d = S_RISE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_RISE: begin
        if (cnt_q == CNT_LIMIT) begin
          state_d  = S_HIGH;
          cnt_d    = '0;
          toggle_d = 1'b1;
        end else if (!btn_s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!btn_s) begin
          state_d = S_FALL;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_FALL: begin
        if (cnt_q == CNT_LIMIT) begin
          state_d   = S_LOW;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (btn_s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    level_d = state_level(state_d);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      toggle_q  <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      toggle_q  <= toggle_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign toggle        = toggle_q;
  assign release_pulse = release_q;

endmodule
